// File: rtl/mod_accum_4049_pkg.sv
// gf4049_pkg: shared constants, FSM state type and the single-subtract
// modular add helper for the mod-4049 datapath.
//   Q       : modulus (4049), must be below 2**W
//   W       : residue width (12)
//   state_t : accumulator FSM states {ACC, OUT}
//   mod_add : (a + b) mod Q, exact only when a + b < 2*Q
package gf4049_pkg;

    localparam int unsigned Q = 4049;
    localparam int unsigned W = 12;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    // The sum is formed at W+1 bits so the carry is kept for the compare.
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= (W+1)'(Q)) ? W'(s - (W+1)'(Q)) : W'(s);
    endfunction

endpackage

// File: rtl/mod_accum_4049_mod_add.sv
// mod_add_4049: combinational W-bit modular adder, o_sum = (i_a + i_b) mod Q.
//   i_a   : first addend, expected < Q
//   i_b   : second addend, expected < Q
//   o_sum : reduced sum
module mod_add_4049
    import gf4049_pkg::*;
(
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    assign o_sum = mod_add(i_a, i_b);

endmodule

// File: rtl/mod_accum_4049.sv
// mod_accum_4049: streaming modular accumulator for residues mod 4049.
// Sums a last-framed stream of residues mod Q and reports the sum and the
// element count on a valid/ready output; one bubble per frame while the
// result is held.
//   clk, rst   : clock, synchronous active-high reset
//   din_*      : residue stream in (din_ready decoded from state only)
//   dout_*     : frame result out (sum mod Q, element count)
//   dout_err   : out-of-range element seen in frame (RANGE_CHECK_EN only)
// Build option: `define RANGE_CHECK_EN to pre-reduce inputs >= Q and flag them.
module mod_accum_4049
    import gf4049_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din_r,
    input  logic             din_valid,
    input  logic             din_last,
    output logic             din_ready,
    output logic [W-1:0]     dout_sum,
    output logic [CNT_W-1:0] dout_count,
    output logic             dout_valid,
    input  logic             dout_ready
`ifdef RANGE_CHECK_EN
    ,
    output logic             dout_err
`endif
);

    state_t           r_state;
    logic [W-1:0]     r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_sum;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;

    logic [W-1:0]     w_din;
    logic [W-1:0]     w_acc_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_accept;

`ifdef RANGE_CHECK_EN
    logic             r_err;
    logic             r_dout_err;
    logic             w_oor;

    // Adding zero through the modular adder is exactly the single
    // conditional subtract needed to fold din_r into [0, Q).
    assign w_oor = (din_r >= W'(Q));
    assign w_din = mod_add(din_r, '0);
    assign dout_err = r_dout_err;
`else
    assign w_din = din_r;
`endif

    mod_add_4049 u_add (
        .i_a   (r_acc),
        .i_b   (w_din),
        .o_sum (w_acc_n)
    );

    assign w_cnt_n  = r_cnt + CNT_W'(1);
    assign din_ready  = (r_state == ACC);
    assign w_accept   = din_valid & din_ready;
    assign dout_sum   = r_sum;
    assign dout_count = r_count;
    assign dout_valid = r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
`ifdef RANGE_CHECK_EN
            r_err      <= 1'b0;
            r_dout_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        if (din_last) begin
                            r_sum   <= w_acc_n;
                            r_count <= w_cnt_n;
                            r_valid <= 1'b1;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= OUT;
`ifdef RANGE_CHECK_EN
                            r_dout_err <= r_err | w_oor;
                            r_err      <= 1'b0;
`endif
                        end else begin
                            r_acc <= w_acc_n;
                            r_cnt <= w_cnt_n;
`ifdef RANGE_CHECK_EN
                            r_err <= r_err | w_oor;
`endif
                        end
                    end
                end
                OUT: begin
                    if (r_valid && dout_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ACC;
                    end
                end
                default: r_state <= ACC;
            endcase
        end
    end

endmodule
